// File: rtl/dm_port_arbiter_pkg.sv
// dm_port_arbiter_pkg: shared FSM state and owner encodings for the data-memory port arbiter
package dm_port_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_C = 2'd1,
    ARB_BUSY_D = 2'd2,
    ARB_DONE   = 2'd3
  } arb_state_e;
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_C    = 2'b01,
    OWN_D    = 2'b10
  } owner_e;
endpackage

// File: rtl/dm_rr_pick.sv
// dm_rr_pick: combinational 2-way round-robin chooser; on a tie the side that did not win last time is granted
module dm_rr_pick (
  input  logic req_c_i,
  input  logic req_d_i,
  input  logic last_d_i,
  output logic gnt_c_o,
  output logic gnt_d_o
);
  assign gnt_c_o = req_c_i & (~req_d_i | last_d_i);
  assign gnt_d_o = req_d_i & (~req_c_i | ~last_d_i);
endmodule

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares one data-memory port between the CPU (C) and a debug/DMA loader (D) with round-robin arbitration
module dm_port_arbiter
  import dm_port_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            c_req_i,
  input  logic            c_we_i,
  input  logic [AW-1:0]   c_addr_i,
  input  logic [DW-1:0]   c_wdata_i,
  input  logic [DW/8-1:0] c_byteen_i,
  output logic [DW-1:0]   c_rdata_o,
  output logic            c_done_o,
  output logic            c_stall_o,
  input  logic            d_req_i,
  input  logic            d_we_i,
  input  logic [AW-1:0]   d_addr_i,
  input  logic [DW-1:0]   d_wdata_i,
  input  logic [DW/8-1:0] d_byteen_i,
  output logic [DW-1:0]   d_rdata_o,
  output logic            d_done_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  output logic [DW/8-1:0] mem_byteen_o,
  input  logic [DW-1:0]   mem_rdata_i,
  input  logic            mem_ack_i,
  output logic [1:0]      owner_o
);
  arb_state_e      state_q;
  owner_e          owner_q;
  logic            last_d_q;
  logic            mem_req_q, mem_we_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q, c_rdata_q, d_rdata_q;
  logic [DW/8-1:0] mem_byteen_q;
  logic            c_done_q, d_done_q;
  logic            gnt_c, gnt_d, g_we;
  logic [AW-1:0]   g_addr;
  logic [DW-1:0]   g_wdata;
  logic [DW/8-1:0] g_be;
  dm_rr_pick u_pick (
    .req_c_i (c_req_i),
    .req_d_i (d_req_i),
    .last_d_i(last_d_q),
    .gnt_c_o (gnt_c),
    .gnt_d_o (gnt_d)
  );
  assign g_we    = gnt_d ? d_we_i     : c_we_i;
  assign g_addr  = gnt_d ? d_addr_i   : c_addr_i;
  assign g_wdata = gnt_d ? d_wdata_i  : c_wdata_i;
  assign g_be    = gnt_d ? d_byteen_i : c_byteen_i;
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWN_NONE;
      last_d_q     <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_byteen_q <= '0;
      c_rdata_q    <= '0;
      d_rdata_q    <= '0;
      c_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
    end else begin
      c_done_q <= 1'b0;
      d_done_q <= 1'b0;
      case (state_q)
        ARB_IDLE:
          if (gnt_c | gnt_d) begin
            last_d_q <= gnt_d;
            owner_q  <= gnt_d ? OWN_D : OWN_C;
            // a write with no lanes enabled completes without touching memory
            if (g_we && g_be == '0) begin
              state_q  <= ARB_DONE;
              c_done_q <= gnt_c;
              d_done_q <= gnt_d;
            end else begin
              state_q      <= gnt_d ? ARB_BUSY_D : ARB_BUSY_C;
              mem_req_q    <= 1'b1;
              mem_we_q     <= g_we;
              mem_addr_q   <= g_addr & ~AW'(3);
              mem_wdata_q  <= g_wdata;
              mem_byteen_q <= g_be;
            end
          end
        ARB_BUSY_C, ARB_BUSY_D:
          if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            state_q   <= ARB_DONE;
            c_done_q  <= state_q == ARB_BUSY_C;
            d_done_q  <= state_q == ARB_BUSY_D;
            if (!mem_we_q && state_q == ARB_BUSY_C) c_rdata_q <= mem_rdata_i;
            if (!mem_we_q && state_q == ARB_BUSY_D) d_rdata_q <= mem_rdata_i;
          end
        ARB_DONE: begin
          state_q <= ARB_IDLE;
          owner_q <= OWN_NONE;
        end
      endcase
    end
  end
  assign c_rdata_o    = c_rdata_q;
  assign d_rdata_o    = d_rdata_q;
  assign c_done_o     = c_done_q;
  assign d_done_o     = d_done_q;
  assign c_stall_o    = c_req_i & ~c_done_q;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign mem_byteen_o = mem_byteen_q;
  assign owner_o      = owner_q;
endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: scoreboard bench for dm_port_arbiter with a latency-programmable memory model
module tb_dm_port_arbiter;
  logic        clk = 0, reset_ni = 0;
  logic        c_req = 0, c_we = 0, d_req = 0, d_we = 0;
  logic [31:0] c_addr = 0, c_wdata = 0, d_addr = 0, d_wdata = 0;
  logic [3:0]  c_byteen = 0, d_byteen = 0;
  logic [31:0] c_rdata, d_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 0;
  logic        c_done, d_done, c_stall, mem_req, mem_we, mem_ack;
  logic [3:0]  mem_byteen;
  logic [1:0]  owner;
  logic        mem_ack_m = 0, ack_force = 0;
  typedef struct {bit d; logic [31:0] rd;} exp_t;
  exp_t        sb[$];
  int          total = 0, bad = 0;
  int          ack_delay = 0, wcnt = 0, req_cyc = 0;
  logic [31:0] exp_c_rd = 0, exp_d_rd = 0;
  logic [31:0] mem_m [logic [31:0]];
  always #5 clk = ~clk;
  assign mem_ack = mem_ack_m | ack_force;
  dm_port_arbiter dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .c_req_i(c_req), .c_we_i(c_we), .c_addr_i(c_addr), .c_wdata_i(c_wdata), .c_byteen_i(c_byteen),
    .c_rdata_o(c_rdata), .c_done_o(c_done), .c_stall_o(c_stall),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_byteen_i(d_byteen),
    .d_rdata_o(d_rdata), .d_done_o(d_done),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_byteen_o(mem_byteen), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack), .owner_o(owner)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] rd_w(input logic [31:0] a);
    return mem_m.exists(a) ? mem_m[a] : a ^ 32'h5A5A_0000;
  endfunction
  task automatic push_exp(input bit d);
    sb.push_back('{d, d ? exp_d_rd : exp_c_rd});
  endtask
  task automatic req(input bit d, input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [3:0] be);
    if (d) begin
      d_req = 1; d_we = we; d_addr = a; d_wdata = wd; d_byteen = be;
      if (!we) exp_d_rd = rd_w(a & ~32'h3);
    end else begin
      c_req = 1; c_we = we; c_addr = a; c_wdata = wd; c_byteen = be;
      if (!we) exp_c_rd = rd_w(a & ~32'h3);
    end
    push_exp(d);
  endtask
  task automatic wait_done(input bit d, input int lim);
    int n;
    for (n = 0; n < lim; n++) begin
      @(negedge clk);
      if (d ? d_done : c_done) break;
    end
    chk(d ? "d_done_timeout" : "c_done_timeout", n < lim, 1);
  endtask
  // memory model: acks after ack_delay wait cycles, returns stored or address-derived data
  always @(negedge clk) begin
    mem_ack_m = 0;
    if (mem_req) begin
      req_cyc++;
      if (wcnt >= ack_delay) begin
        mem_ack_m = 1;
        mem_rdata = rd_w(mem_addr);
        wcnt = 0;
      end else wcnt++;
    end else wcnt = 0;
  end
  always @(posedge clk) begin
    logic [31:0] w;
    if (reset_ni && mem_req && mem_ack && mem_we) begin
      w = rd_w(mem_addr);
      for (int b = 0; b < 4; b++) if (mem_byteen[b]) w[8*b+:8] = mem_wdata[8*b+:8];
      mem_m[mem_addr] = w;
    end
  end
  always @(negedge clk) begin
    exp_t e;
    if (reset_ni && (c_done || d_done)) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      chk("one_done", c_done & d_done, 0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("done_port", d_done, e.d);
        chk("rdata", d_done ? d_rdata : c_rdata, e.rd);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [68:0] snap;
    int n, rc;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", mem_byteen, 0);
    chk("rst_c_done", c_done, 0);
    chk("rst_d_done", d_done, 0);
    chk("rst_c_rdata", c_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_owner", owner, 0);
    reset_ni = 1;
    @(negedge clk);
    // tie right after reset: C first, D after one idle cycle
    req(0, 32'h3000, 0, 0, 4'hF);
    req(1, 32'h2000, 0, 0, 4'hF);
    @(negedge clk);
    chk("t2_owner_c", owner, 2'b01);
    chk("t2_addr_c", mem_addr, 32'h3000);
    wait_done(0, 10);
    c_req = 0;
    @(negedge clk);
    chk("t2_gap_owner", owner, 2'b00);
    chk("t2_gap_req", mem_req, 0);
    @(negedge clk);
    chk("t2_owner_d", owner, 2'b10);
    chk("t2_addr_d", mem_addr, 32'h2000);
    wait_done(1, 10);
    d_req = 0;
    @(negedge clk);
    // continuous load alternates C,D,C,D,C,D
    req(0, 32'h3000, 0, 0, 4'hF);
    req(1, 32'h2000, 0, 0, 4'hF);
    for (int i = 0; i < 2; i++) begin
      push_exp(0);
      push_exp(1);
    end
    for (int i = 0; i < 6; i++) begin
      for (n = 0; n < 8; n++) begin
        @(negedge clk);
        if (c_done || d_done) break;
      end
      chk("t3_wait", n, i == 0 ? 1 : 2);
      chk("t3_order", d_done, i % 2);
      if (i == 5) begin
        c_req = 0;
        d_req = 0;
      end
    end
    @(negedge clk);
    // single CPU read with sub-word address
    mem_m[32'h1004] = 32'hDEAD_BEEF;
    req(0, 32'h1006, 0, 0, 4'hF);
    #1 chk("t1_stall_n", c_stall, 1);
    @(negedge clk);
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 32'h1004);
    chk("t1_mem_we", mem_we, 0);
    chk("t1_owner", owner, 2'b01);
    chk("t1_stall_n1", c_stall, 1);
    @(negedge clk);
    chk("t1_done", c_done, 1);
    chk("t1_rdata", c_rdata, 32'hDEAD_BEEF);
    chk("t1_stall_n2", c_stall, 0);
    c_req = 0;
    @(negedge clk);
    // D write held off by a slow memory while C waits
    ack_delay = 5;
    req(1, 32'h40, 1, 32'h0000_AB00, 4'b0010);
    @(negedge clk);
    chk("t4_req", mem_req, 1);
    snap = {mem_we, mem_addr, mem_wdata, mem_byteen};
    req(0, 32'h3000, 0, 0, 4'hF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold", {mem_we, mem_addr, mem_wdata, mem_byteen} == snap, 1);
      chk("t4_req_held", mem_req, 1);
      chk("t4_c_stall", c_stall, 1);
      chk("t4_no_done", d_done, 0);
    end
    wait_done(1, 5);
    chk("t4_c_stall_done", c_stall, 1);
    d_req = 0;
    ack_delay = 0;
    chk("t4_mem", rd_w(32'h40), 32'h5A5A_AB40);
    wait_done(0, 10);
    c_req = 0;
    @(negedge clk);
    // zero byte-enable write: no memory access, done one cycle earlier
    rc = req_cyc;
    req(0, 32'h50, 1, 32'hFFFF_FFFF, 4'b0000);
    @(negedge clk);
    chk("t5_done", c_done, 1);
    chk("t5_no_req", mem_req, 0);
    chk("t5_owner", owner, 2'b01);
    chk("t5_rdata", c_rdata, 32'h5A5A_3000);
    c_req = 0;
    @(negedge clk);
    chk("t5_no_mem_cycles", req_cyc, rc);
    chk("t5_mem", rd_w(32'h50), 32'h5A5A_0050);
    ack_force = 1;
    @(negedge clk);
    ack_force = 0;
    chk("spur_owner", owner, 0);
    chk("spur_done", c_done | d_done, 0);
    chk("spur_req", mem_req, 0);
    // reset in BUSY_C with no ack
    ack_delay = 10;
    req(0, 32'h3000, 0, 0, 4'hF);
    @(negedge clk);
    chk("t6_busy_owner", owner, 2'b01);
    chk("t6_busy_req", mem_req, 1);
    reset_ni = 0;
    c_req = 0;
    @(negedge clk);
    chk("t6_req", mem_req, 0);
    chk("t6_owner", owner, 0);
    chk("t6_done", c_done, 0);
    chk("t6_rdata", c_rdata, 0);
    sb.delete();
    exp_c_rd = 0;
    exp_d_rd = 0;
    ack_delay = 0;
    reset_ni = 1;
    @(negedge clk);
    req(0, 32'h3008, 0, 0, 4'hF);
    req(1, 32'h200C, 0, 0, 4'hF);
    @(negedge clk);
    chk("t6_tie_owner", owner, 2'b01);
    wait_done(0, 10);
    c_req = 0;
    wait_done(1, 10);
    d_req = 0;
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
